// File: rtl/x9_dbg_pkg.sv
// Shared types and default sizing for the register-dump debug block.
package x9_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SEND   = 2'd2,
        ST_FINISH = 2'd3
    } dump_state_e;

    localparam int NUM_REGS_DEF = 8;
    localparam int DATA_W_DEF   = 8;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Streams every register-file entry out over a valid/ready port once the core
// signals program completion, one read-then-send pair per register.
module reg_dump_ctrl
    import x9_dbg_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_done,
    output logic [AW-1:0]     rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [AW-1:0]     dump_addr,
    output logic              dump_last,
    output logic              dump_busy,
    output logic              dump_complete
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    dump_state_e       state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [AW-1:0]     addr_q, addr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = core_done;
        data_d  = data_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                // Only a rising edge of core_done starts a dump.
                if (core_done && !done_q) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                end
            end
            ST_FETCH: begin
                data_d  = rf_rdata;
                addr_d  = idx_q;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                if (!core_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The beat is presented straight from the hold registers so it cannot
    // change while the consumer stalls.
    assign rf_raddr      = idx_q;
    assign dump_valid    = (state_q == ST_SEND);
    assign dump_data     = data_q;
    assign dump_addr     = addr_q;
    assign dump_last     = (state_q == ST_SEND) && (addr_q == LAST_IDX);
    assign dump_busy     = (state_q == ST_FETCH) || (state_q == ST_SEND);
    assign dump_complete = (state_q == ST_FINISH);

endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of register-file entries dumped.
REQ-002 SHALL have parameter DATA_W, default 8, register data width.
REQ-003 SHALL have parameter AW, default $clog2(NUM_REGS), register address width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 core_done  input  1  core program-complete level from top_level.
REQ-007 rf_raddr  output  AW  debug read address into the register file.
REQ-008 rf_rdata  input  DATA_W  combinational register-file read data for rf_raddr.
REQ-009 dump_valid  output  1  dump_data, dump_addr and dump_last are valid.
REQ-010 dump_ready  input  1  consumer accepts the current beat.
REQ-011 dump_data  output  DATA_W  register value.
REQ-012 dump_addr  output  AW  register index of dump_data.
REQ-013 dump_last  output  1  high on the beat for index NUM_REGS-1.
REQ-014 dump_busy  output  1  high in FETCH and SEND.
REQ-015 dump_complete  output  1  high in FINISH.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, SEND and FINISH.
REQ-017 A start SHALL be core_done==1 with registered done_q==0 while in IDLE (rising edge); done_q SHALL update every cycle.
REQ-018 IDLE->FETCH on start; idx SHALL load 0.
REQ-019 In FETCH, rf_raddr SHALL equal idx; at the clock edge rf_rdata SHALL be captured into the data hold register, idx into the addr hold register, and the state SHALL move to SEND.
REQ-020 In SEND, dump_valid SHALL be 1; dump_data, dump_addr and dump_last SHALL remain stable while dump_valid && !dump_ready.
REQ-021 SEND with dump_ready: if idx==NUM_REGS-1, go to FINISH; otherwise idx increments and the state goes to FETCH.
REQ-022 FINISH SHALL hold until core_done==0, then go to IDLE.
REQ-023 Latency: start sampled at edge N gives FETCH in cycle N+1 and the first dump_valid in cycle N+2; each beat then costs 2 cycles with dump_ready held high, giving 2*NUM_REGS cycles from start to FINISH.
REQ-024 core_done falling mid-dump SHALL be ignored, and the dump SHALL run to completion.
REQ-025 A core_done rising edge outside IDLE SHALL NOT restart the dump.
REQ-026 idx SHALL never exceed NUM_REGS-1; there is no wrap-around.
REQ-027 Outside FETCH, rf_raddr SHALL hold idx.
REQ-028 dump_valid SHALL be 0 in IDLE, FETCH and FINISH.

Reset
REQ-029 Reset low SHALL asynchronously force state IDLE, idx=0, done_q=0, hold registers=0, and every output to 0.
REQ-030 Reset asserted mid-dump SHALL abort the dump; no beat may appear until the next start after release.
REQ-031 core_done already high at reset release SHALL count as a start, because done_q resets to 0.

Structure
REQ-032 Package x9_dbg_pkg SHALL hold the state enum type and the NUM_REGS/DATA_W default constants.
REQ-033 The block SHALL be a single module with no sub-modules; top_level SHALL connect it to a second, read-only register-file port.

Verification
REQ-034 Preload core[0..7]=8'h10..8'h17; pulse core_done with dump_ready=1 -> 8 beats, addr 0..7 in order, data 10..17, dump_last only on addr 7, then dump_complete=1.
REQ-035 Same preload; dump_ready=0 for 5 cycles on beat 3 -> dump_valid held, dump_data=8'h13 and dump_addr=3 stable throughout, no beat lost or duplicated.
REQ-036 Drop core_done after beat 2 -> all 8 beats still sent; FINISH exits to IDLE in the next cycle.
REQ-037 Assert reset low during beat 4 -> all outputs 0 within the same cycle; after release with core_done=0, no beats appear; a new core_done edge gives a full dump starting at addr 0.
REQ-038 Hold core_done=1 through reset release -> one full dump; a second core_done pulse during FINISH causes no restart.
REQ-039 Core core[1]=8'd42, core[5]=8'd7 -> beat with addr 1 has data 42, beat with addr 5 has data 7, matching the direct register-file read.
